// File: rtl/parl_add_pkg.sv
// Shared definitions for the pipelined adder tree and vector accumulator.
package parl_add_pkg;

    // Width of the scratch vector used by the saturation-limit helpers.
    localparam int unsigned SAT_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Number of tree levels: ceil(log2(n)).
    function automatic int unsigned stage_count(input int unsigned n);
        int unsigned d;
        d = 0;
        while ((64'd1 << d) < 64'(n)) d = d + 1;
        return d;
    endfunction

    // Operand count after zero-padding up to a power of two.
    function automatic int unsigned padded_count(input int unsigned n);
        return 32'd1 << stage_count(n);
    endfunction

    // Largest representable value of a width/signedness, in the low bits.
    function automatic logic [SAT_W-1:0] sat_max(input int unsigned width, input bit is_signed);
        logic [SAT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) r[i] = 1'b1;
        if (is_signed) r[width-1] = 1'b0;
        return r;
    endfunction

    // Smallest representable value of a width/signedness, in the low bits.
    function automatic logic [SAT_W-1:0] sat_min(input int unsigned width, input bit is_signed);
        logic [SAT_W-1:0] r;
        r = '0;
        if (is_signed) r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/parl_add_stage.sv
// One registered adder-tree level: sums adjacent operand pairs, carries
// valid and the vector-last tag alongside the data.
module parl_add_stage #(
    parameter  int unsigned IN_COUNT  = 2,
    parameter  int unsigned WIDTH     = 8,
    localparam int unsigned OUT_COUNT = IN_COUNT / 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [IN_COUNT*WIDTH-1:0]  in_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [OUT_COUNT*WIDTH-1:0] out_data
);

    logic                       valid_q, valid_d;
    logic                       last_q,  last_d;
    logic [OUT_COUNT*WIDTH-1:0] data_q,  data_d;

    // Pairwise sums; data and last only load on a valid beat.
    always_comb begin
        valid_d = in_valid;
        last_d  = last_q;
        data_d  = data_q;
        if (in_valid) begin
            last_d = in_last;
            for (int unsigned j = 0; j < OUT_COUNT; j++) begin
                data_d[j*WIDTH +: WIDTH] = in_data[(2*j)*WIDTH +: WIDTH]
                                         + in_data[(2*j+1)*WIDTH +: WIDTH];
            end
        end
    end

    // Level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = data_q;

endmodule

// File: rtl/parl_add_tree_acc.sv
// Pipelined N-input adder tree followed by a per-vector accumulator that
// emits one sum, sticky overflow flag and beat count per last-delimited vector.
module parl_add_tree_acc
    import parl_add_pkg::*;
#(
    parameter  int unsigned OPERAND_WIDTH = 18,
    parameter  int unsigned NUM_INPUTS    = 8,
    parameter  bit          SIGNED        = 1'b1,
    parameter  int unsigned ACC_EXTRA     = 8,
    parameter  bit          SATURATE      = 1'b1,
    parameter  int unsigned CNT_WIDTH     = 8,
    localparam int unsigned D             = stage_count(NUM_INPUTS),
    localparam int unsigned PAD           = padded_count(NUM_INPUTS),
    localparam int unsigned TREE_WIDTH    = OPERAND_WIDTH + D,
    localparam int unsigned ACC_WIDTH     = TREE_WIDTH + ACC_EXTRA
) (
    input  logic                                parl_add_tree_clk,
    input  logic                                parl_add_tree_rst_b,
    input  logic                                in_valid_i,
    input  logic                                in_last_i,
    input  logic [NUM_INPUTS*OPERAND_WIDTH-1:0] in_data_i,
    output logic                                out_valid_o,
    output logic [ACC_WIDTH-1:0]                out_sum_o,
    output logic                                out_ovf_o,
    output logic [CNT_WIDTH-1:0]                out_beats_o
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED));

    logic [PAD*TREE_WIDTH-1:0] lvl0_data;
    logic [OPERAND_WIDTH-1:0]  op;

    // Extend each operand to the tree width; pad slots stay zero.
    always_comb begin
        lvl0_data = '0;
        op        = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            op = in_data_i[k*OPERAND_WIDTH +: OPERAND_WIDTH];
            lvl0_data[k*TREE_WIDTH +: TREE_WIDTH] = {{D{SIGNED & op[OPERAND_WIDTH-1]}}, op};
        end
    end

    genvar l;
    generate
        for (l = 0; l < D; l++) begin : g_lvl
            localparam int unsigned IN_CNT = PAD >> l;
            logic [(IN_CNT/2)*TREE_WIDTH-1:0] data;
            logic                             valid;
            logic                             last;
            if (l == 0) begin : g_first
                parl_add_stage #(.IN_COUNT(IN_CNT), .WIDTH(TREE_WIDTH)) u_stage (
                    .clk       (parl_add_tree_clk),
                    .rst_n     (parl_add_tree_rst_b),
                    .in_valid  (in_valid_i),
                    .in_last   (in_last_i),
                    .in_data   (lvl0_data),
                    .out_valid (valid),
                    .out_last  (last),
                    .out_data  (data)
                );
            end else begin : g_next
                parl_add_stage #(.IN_COUNT(IN_CNT), .WIDTH(TREE_WIDTH)) u_stage (
                    .clk       (parl_add_tree_clk),
                    .rst_n     (parl_add_tree_rst_b),
                    .in_valid  (g_lvl[l-1].valid),
                    .in_last   (g_lvl[l-1].last),
                    .in_data   (g_lvl[l-1].data),
                    .out_valid (valid),
                    .out_last  (last),
                    .out_data  (data)
                );
            end
        end
    endgenerate

    logic [TREE_WIDTH-1:0] tree_sum;
    logic                  tree_valid;
    logic                  tree_last;

    assign tree_sum   = g_lvl[D-1].data;
    assign tree_valid = g_lvl[D-1].valid;
    assign tree_last  = g_lvl[D-1].last;

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [CNT_WIDTH-1:0] out_beats_q, out_beats_d;

    logic                 first;
    logic [ACC_WIDTH:0]   sum_x, base_x, res;
    logic                 ovf_now, ovf_new;
    logic [ACC_WIDTH-1:0] acc_new;
    logic [CNT_WIDTH-1:0] cnt_new;

    // Accumulate tree sums; the extra top bit of res exposes carry/sign for overflow.
    always_comb begin
        first   = (state_q == IDLE);
        sum_x   = {{(ACC_EXTRA + 1){SIGNED & tree_sum[TREE_WIDTH-1]}}, tree_sum};
        base_x  = first ? '0 : {SIGNED & acc_q[ACC_WIDTH-1], acc_q};
        res     = base_x + sum_x;
        ovf_now = SIGNED ? (res[ACC_WIDTH] ^ res[ACC_WIDTH-1]) : res[ACC_WIDTH];
        if (!ovf_now || !SATURATE) acc_new = res[ACC_WIDTH-1:0];
        else if (SIGNED && res[ACC_WIDTH]) acc_new = ACC_MIN;
        else acc_new = ACC_MAX;
        ovf_new = ovf_now | (!first & ovf_q);
        if (first) cnt_new = CNT_WIDTH'(1);
        else if (&cnt_q) cnt_new = cnt_q;
        else cnt_new = cnt_q + CNT_WIDTH'(1);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;

        if (tree_valid) begin
            if (tree_last) begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
                out_sum_d   = acc_new;
                out_ovf_d   = ovf_new;
                out_beats_d = cnt_new;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_new;
                cnt_d   = cnt_new;
                ovf_d   = ovf_new;
            end
        end
    end

    // Accumulator, FSM and output registers.
    always_ff @(posedge parl_add_tree_clk or negedge parl_add_tree_rst_b) begin
        if (!parl_add_tree_rst_b) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_beats_o = out_beats_q;

endmodule

// File: tb/tb_parl_add_tree_acc.sv
// Directed bench for parl_add_tree_acc across four parameter sets.
module tb_parl_add_tree_acc;

    localparam int unsigned OW = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // A: 8 inputs, signed, ACC_EXTRA 8
    logic             a_valid, a_last;
    logic [8*OW-1:0]  a_data;
    logic             a_ovalid, a_ovf;
    logic [28:0]      a_sum;
    logic [7:0]       a_beats;
    int unsigned      a_issue;
    // B: 5 inputs, unsigned
    logic             b_valid, b_last;
    logic [5*OW-1:0]  b_data;
    logic             b_ovalid, b_ovf;
    logic [28:0]      b_sum;
    logic [7:0]       b_beats;
    // C (saturate) and D (wrap): 8 inputs, signed, no guard bits; shared inputs
    logic             c_valid, c_last;
    logic [8*OW-1:0]  c_data;
    logic             c_ovalid, c_ovf, d_ovalid, d_ovf;
    logic [20:0]      c_sum, d_sum;
    logic [7:0]       c_beats, d_beats;

    parl_add_tree_acc #(.OPERAND_WIDTH(18), .NUM_INPUTS(8), .SIGNED(1'b1),
                        .ACC_EXTRA(8), .SATURATE(1'b1), .CNT_WIDTH(8)) u_dut_a (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_n),
        .in_valid_i(a_valid), .in_last_i(a_last), .in_data_i(a_data),
        .out_valid_o(a_ovalid), .out_sum_o(a_sum), .out_ovf_o(a_ovf), .out_beats_o(a_beats));

    parl_add_tree_acc #(.OPERAND_WIDTH(18), .NUM_INPUTS(5), .SIGNED(1'b0),
                        .ACC_EXTRA(8), .SATURATE(1'b1), .CNT_WIDTH(8)) u_dut_b (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_n),
        .in_valid_i(b_valid), .in_last_i(b_last), .in_data_i(b_data),
        .out_valid_o(b_ovalid), .out_sum_o(b_sum), .out_ovf_o(b_ovf), .out_beats_o(b_beats));

    parl_add_tree_acc #(.OPERAND_WIDTH(18), .NUM_INPUTS(8), .SIGNED(1'b1),
                        .ACC_EXTRA(0), .SATURATE(1'b1), .CNT_WIDTH(8)) u_dut_c (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_n),
        .in_valid_i(c_valid), .in_last_i(c_last), .in_data_i(c_data),
        .out_valid_o(c_ovalid), .out_sum_o(c_sum), .out_ovf_o(c_ovf), .out_beats_o(c_beats));

    parl_add_tree_acc #(.OPERAND_WIDTH(18), .NUM_INPUTS(8), .SIGNED(1'b1),
                        .ACC_EXTRA(0), .SATURATE(1'b0), .CNT_WIDTH(8)) u_dut_d (
        .parl_add_tree_clk(clk), .parl_add_tree_rst_b(rst_n),
        .in_valid_i(c_valid), .in_last_i(c_last), .in_data_i(c_data),
        .out_valid_o(d_ovalid), .out_sum_o(d_sum), .out_ovf_o(d_ovf), .out_beats_o(d_beats));

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
        logic [7:0]  beats;
        int unsigned cyc;
    } res_t;

    res_t qa[$], qb[$], qc[$], qd[$];

    always @(negedge clk) begin
        if (a_ovalid) qa.push_back('{64'(a_sum), a_ovf, a_beats, cyc});
        if (b_ovalid) qb.push_back('{64'(b_sum), b_ovf, b_beats, cyc});
        if (c_ovalid) qc.push_back('{64'(c_sum), c_ovf, c_beats, cyc});
        if (d_ovalid) qd.push_back('{64'(d_sum), d_ovf, d_beats, cyc});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t r, input logic [63:0] sum,
                             input logic ovf, input logic [7:0] beats);
        check({tag, "_sum"}, r.sum, sum);
        check({tag, "_ovf"}, 64'(r.ovf), 64'(ovf));
        check({tag, "_beats"}, 64'(r.beats), 64'(beats));
    endtask

    // Operand k = first + k*step (modulo 2^18).
    task automatic beat_a(input logic last, input logic [OW-1:0] first, input logic [OW-1:0] step);
        logic [OW-1:0] v;
        v = first;
        for (int k = 0; k < 8; k++) begin
            a_data[k*OW +: OW] = v;
            v = v + step;
        end
        a_valid = 1'b1;
        a_last  = last;
        a_issue = cyc;
        @(negedge clk);
    endtask

    task automatic beat_b(input logic last);
        b_data  = '1;
        b_valid = 1'b1;
        b_last  = last;
        @(negedge clk);
    endtask

    task automatic beat_c(input logic last, input logic [OW-1:0] first, input logic [OW-1:0] step);
        logic [OW-1:0] v;
        v = first;
        for (int k = 0; k < 8; k++) begin
            c_data[k*OW +: OW] = v;
            v = v + step;
        end
        c_valid = 1'b1;
        c_last  = last;
        @(negedge clk);
    endtask

    // Idle cycles; a_last is left high to show last without valid is ignored.
    task automatic idle_all(input int n);
        a_valid = 1'b0; a_last = 1'b1;
        b_valid = 1'b0; b_last = 1'b0;
        c_valid = 1'b0; c_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int unsigned issue;

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0; a_last = 1'b0; a_data = '0; a_issue = 0;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0;
        c_valid = 1'b0; c_last = 1'b0; c_data = '0;
        repeat (3) @(negedge clk);

        check("rst_valid", 64'(a_ovalid), 64'd0);
        check("rst_sum",   64'(a_sum),    64'd0);
        check("rst_ovf",   64'(a_ovf),    64'd0);
        check("rst_beats", 64'(a_beats),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat 1..8
        qa.delete();
        beat_a(1'b1, 18'd1, 18'd1);
        issue = a_issue;
        idle_all(8);
        check("single_cnt", 64'(qa.size()), 64'd1);
        if (qa.size() >= 1) begin
            check_res("single", qa[0], 64'd36, 1'b0, 8'd1);
            check("single_lat", 64'(qa[0].cyc - issue), 64'd4);
        end
        check("hold_sum",   64'(a_sum),    64'd36);
        check("hold_valid", 64'(a_ovalid), 64'd0);

        // Three beats of -1 with gaps
        qa.delete();
        beat_a(1'b0, 18'h3FFFF, 18'd0);
        idle_all(2);
        beat_a(1'b0, 18'h3FFFF, 18'd0);
        idle_all(3);
        beat_a(1'b1, 18'h3FFFF, 18'd0);
        idle_all(8);
        check("neg_cnt", 64'(qa.size()), 64'd1);
        if (qa.size() >= 1) check_res("neg", qa[0], 64'h1FFF_FFE8, 1'b0, 8'd3);

        // Padding, unsigned, two beats of all-ones operands
        qb.delete();
        beat_b(1'b0);
        beat_b(1'b1);
        idle_all(8);
        check("pad_cnt", 64'(qb.size()), 64'd1);
        if (qb.size() >= 1) check_res("pad", qb[0], 64'd2621430, 1'b0, 8'd2);

        // Overflow: saturate (C) and wrap (D)
        qc.delete();
        qd.delete();
        beat_c(1'b0, 18'h1FFFF, 18'd0);
        beat_c(1'b1, 18'h1FFFF, 18'd0);
        idle_all(8);
        check("sat_cnt",  64'(qc.size()), 64'd1);
        check("wrap_cnt", 64'(qd.size()), 64'd1);
        if (qc.size() >= 1) check_res("sat",  qc[0], 64'h0F_FFFF, 1'b1, 8'd2);
        if (qd.size() >= 1) check_res("wrap", qd[0], 64'h1F_FFF0, 1'b1, 8'd2);
        qc.delete();
        qd.delete();
        beat_c(1'b1, 18'd1, 18'd1);
        idle_all(8);
        check("post_sat_cnt",  64'(qc.size()), 64'd1);
        check("post_wrap_cnt", 64'(qd.size()), 64'd1);
        if (qc.size() >= 1) check_res("post_sat",  qc[0], 64'd36, 1'b0, 8'd1);
        if (qd.size() >= 1) check_res("post_wrap", qd[0], 64'd36, 1'b0, 8'd1);

        // Back-to-back vectors of 1, 2, 1 beats
        qa.delete();
        beat_a(1'b1, 18'd1, 18'd0);
        beat_a(1'b0, 18'd2, 18'd0);
        beat_a(1'b1, 18'd3, 18'd0);
        beat_a(1'b1, 18'd4, 18'd0);
        idle_all(8);
        check("b2b_cnt", 64'(qa.size()), 64'd3);
        if (qa.size() >= 3) begin
            check_res("b2b0", qa[0], 64'd8,  1'b0, 8'd1);
            check_res("b2b1", qa[1], 64'd40, 1'b0, 8'd2);
            check_res("b2b2", qa[2], 64'd32, 1'b0, 8'd1);
            check("b2b_gap01", 64'(qa[1].cyc - qa[0].cyc), 64'd2);
            check("b2b_gap12", 64'(qa[2].cyc - qa[1].cyc), 64'd1);
        end

        // Reset after 2 of 4 beats
        qa.delete();
        beat_a(1'b0, 18'd1, 18'd0);
        beat_a(1'b0, 18'd1, 18'd0);
        a_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("mid_rst_sum",   64'(a_sum),    64'd0);
        check("mid_rst_beats", 64'(a_beats),  64'd0);
        check("mid_rst_valid", 64'(a_ovalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_all(6);
        check("mid_rst_nopulse", 64'(qa.size()), 64'd0);
        beat_a(1'b1, 18'd1, 18'd1);
        idle_all(8);
        check("fresh_cnt", 64'(qa.size()), 64'd1);
        if (qa.size() >= 1) check_res("fresh", qa[0], 64'd36, 1'b0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
